// File: rtl/cpu_pacer_pkg.sv
// Shared defaults and types for the CPU clock pacer and its timer front end.
package cpu_pacer_pkg;

  localparam int DIV_W_DEF   = 5;
  localparam int DEB_LEN_DEF = 2;

  // Board default divisor: period of 22 clocks (1/22 rate).
  localparam int DIV_RST = 21;

  typedef enum logic {
    MODE_FULL = 1'b0,
    MODE_SLOW = 1'b1
  } mode_e;

endpackage

// File: rtl/cpu_pacer_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cpu_pacer.sv
// CPU clock-enable pacer with boundary-aligned divisor/mode changes, plus
// 50 Hz timer edge detection, button debounce/toggle and gated timer event.
import cpu_pacer_pkg::*;

module cpu_pacer #(
  parameter int   DIV_W    = DIV_W_DEF,
  parameter int   DEB_LEN  = DEB_LEN_DEF,
  parameter logic TMR_INIT = 1'b0
) (
  input  logic             clk_p,
  input  logic             dclo,
  input  logic             cpuslow,
  input  logic [DIV_W-1:0] div_n,
  output logic             cpu_clk_ena,
  input  logic             timer_50,
  input  logic             timer_button,
  output logic             timer_status,
  output logic             vm_evnt,
  output logic             tick
);

  logic [DIV_W-1:0]   cnt;
  logic [DIV_W-1:0]   div_cur;
  mode_e              mode_r;
  logic               at_end;

  logic               t50_s;
  logic               btn_s;
  logic               t50_prev;
  logic [DEB_LEN-1:0] deb;
  logic [DEB_LEN-1:0] deb_nx;
  logic               armed;

  // Divisor and mode are only adopted on the last clock of a period.
  assign at_end = (cnt == div_cur);

  always_ff @(posedge clk_p) begin
    if (dclo) begin
      cnt     <= '0;
      div_cur <= div_n;
      mode_r  <= mode_e'(cpuslow);
    end else if (at_end) begin
      cnt     <= '0;
      div_cur <= div_n;
      mode_r  <= mode_e'(cpuslow);
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

  assign cpu_clk_ena = (mode_r == MODE_FULL) || (cnt == '0);

  sync2 u_sync_t50 (
    .clk (clk_p),
    .rst (dclo),
    .d   (timer_50),
    .q   (t50_s)
  );

  sync2 u_sync_btn (
    .clk (clk_p),
    .rst (dclo),
    .d   (timer_button),
    .q   (btn_s)
  );

  always_ff @(posedge clk_p) begin
    if (dclo) begin
      t50_prev <= 1'b0;
      tick     <= 1'b0;
      vm_evnt  <= 1'b0;
    end else begin
      t50_prev <= t50_s;
      tick     <= t50_s & ~t50_prev;
      vm_evnt  <= t50_s & timer_status;
    end
  end

  // The toggle decision looks at the history including the sample taken on this tick.
  assign deb_nx = {deb[DEB_LEN-2:0], btn_s};

  always_ff @(posedge clk_p) begin
    if (dclo) begin
      deb          <= '0;
      armed        <= 1'b1;
      timer_status <= TMR_INIT;
    end else if (tick) begin
      deb <= deb_nx;
      if ((&deb_nx) && armed) begin
        timer_status <= ~timer_status;
        armed        <= 1'b0;
      end else if (~|deb_nx) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_pacer.sv
// Randomized scoreboard bench for cpu_pacer against a behavioural reference model.
module tb_cpu_pacer;

  localparam int   DIV_W    = 5;
  localparam int   DEB_LEN  = 2;
  localparam logic TMR_INIT = 1'b0;
  localparam int   NCYC     = 6000;

  logic             clk_p;
  logic             dclo;
  logic             cpuslow;
  logic [DIV_W-1:0] div_n;
  logic             cpu_clk_ena;
  logic             timer_50;
  logic             timer_button;
  logic             timer_status;
  logic             vm_evnt;
  logic             tick;

  cpu_pacer #(
    .DIV_W    (DIV_W),
    .DEB_LEN  (DEB_LEN),
    .TMR_INIT (TMR_INIT)
  ) dut (
    .clk_p        (clk_p),
    .dclo         (dclo),
    .cpuslow      (cpuslow),
    .div_n        (div_n),
    .cpu_clk_ena  (cpu_clk_ena),
    .timer_50     (timer_50),
    .timer_button (timer_button),
    .timer_status (timer_status),
    .vm_evnt      (vm_evnt),
    .tick         (tick)
  );

  initial clk_p = 1'b0;
  always #5 clk_p = ~clk_p;

  typedef struct packed {
    logic ena;
    logic tck;
    logic status;
    logic vm;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state, described in terms of periods and input delay lines.
  int remain;
  bit first_clk, slow;
  bit t50_seen, t50_sync, t50_sync_old;
  bit btn_seen, btn_sync;
  bit tick_m, status_m, armed_m, vm_m;
  bit press_hist[$];

  task model_step(input bit rst, input bit t50, input bit btn,
                  input bit cs, input int dn, output exp_t e);
    bit old_status;
    int ones;
    old_status = status_m;
    if (rst) begin
      status_m = TMR_INIT;
      armed_m  = 1'b1;
      press_hist = {};
      for (int i = 0; i < DEB_LEN; i++) press_hist.push_back(1'b0);
    end else if (tick_m) begin
      press_hist.push_back(btn_sync);
      void'(press_hist.pop_front());
      ones = 0;
      foreach (press_hist[i]) ones += press_hist[i];
      if (ones == DEB_LEN && armed_m) begin
        status_m = ~status_m;
        armed_m  = 1'b0;
      end else if (ones == 0) begin
        armed_m = 1'b1;
      end
    end
    vm_m   = !rst && t50_sync && old_status;
    tick_m = !rst && t50_sync && !t50_sync_old;
    t50_sync_old = rst ? 1'b0 : t50_sync;
    t50_sync     = rst ? 1'b0 : t50_seen;
    t50_seen     = rst ? 1'b0 : t50;
    btn_sync     = rst ? 1'b0 : btn_seen;
    btn_seen     = rst ? 1'b0 : btn;
    if (rst || remain == 0) begin
      remain    = dn;
      first_clk = 1'b1;
      slow      = cs;
    end else begin
      remain--;
      first_clk = 1'b0;
    end
    e.ena    = !slow || first_clk;
    e.tck    = tick_m;
    e.status = status_m;
    e.vm     = vm_m;
  endtask

  task check1(input string name, input logic act, input logic req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk_p);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        check1("cpu_clk_ena", cpu_clk_ena, e.ena);
        check1("tick", tick, e.tck);
        check1("timer_status", timer_status, e.status);
        check1("vm_evnt", vm_evnt, e.vm);
      end
    end
  end

  initial begin
    exp_t e;
    int   drain;
    dclo = 1'b1; cpuslow = 1'b1; div_n = DIV_W'(21);
    timer_50 = 1'b0; timer_button = 1'b0;
    remain = 0; first_clk = 1'b0; slow = 1'b0;
    t50_seen = 0; t50_sync = 0; t50_sync_old = 0; btn_seen = 0; btn_sync = 0;
    tick_m = 0; status_m = 0; armed_m = 1; vm_m = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk_p);
      dclo = (c < 3) || ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) timer_50 = ~timer_50;
      if (((c / 500) % 4) == 3)
        timer_button = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 39) == 0)
        timer_button = ~timer_button;
      if ($urandom_range(0, 59) == 0) cpuslow = ~cpuslow;
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0:       div_n = DIV_W'($urandom_range(0, 3));
          1:       div_n = DIV_W'(21);
          default: div_n = DIV_W'($urandom_range(0, 31));
        endcase
      end
      model_step(dclo, timer_50, timer_button, cpuslow, int'(div_n), e);
      exp_q.push_back(e);
    end
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk_p);
      drain++;
    end
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
